apb_i2c_regbank: RTL and testbench

APB_I2C_REGBANK -- requirements
Module: apb_i2c_regbank

---
 rtl/apb_i2c_regbank.sv | 151 +++++++++++++++
 tb/tb_apb_i2c_regbank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_regbank.sv
// APB slave register bank for an I2C core: TX/RX FIFO ports with bounded wait states,
// status/interrupt registers and a bank of configuration registers.
module apb_i2c_regbank #(
    parameter int DATA_W    = 32,
    parameter int NUM_CFG   = 4,
    parameter int CFG_W     = 14,
    parameter int STALL_MAX = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     PSELx,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [7:0]               PADDR,
    input  logic [DATA_W-1:0]        PWDATA,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [DATA_W-1:0]        TX_WDATA,
    output logic                     TX_WR,
    input  logic                     TX_FULL,
    input  logic                     TX_EMPTY,
    input  logic [DATA_W-1:0]        RX_RDATA,
    output logic                     RX_RD,
    input  logic                     RX_EMPTY,
    input  logic                     ERROR,
    output logic [NUM_CFG*CFG_W-1:0] CFG_REGS,
    output logic                     IRQ
);

    localparam logic [9:0] STALL_LIM = 10'(STALL_MAX);
    localparam logic [3:0] NCFG      = 4'(NUM_CFG);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

    state_t           state_q, state_d, cur_st;
    logic [9:0]       cnt_q, cnt_d, cnt_eff;
    logic [CFG_W-1:0] cfg_q [NUM_CFG];
    logic [3:0]       ien_q, ist_q, ist_d, ist_set, ist_clr;
    logic             tx_empty_q, rx_empty_q, error_q, irq_q;

    logic             hit_tx, hit_rx, hit_stat, hit_ien, hit_ist, cfg_hit;
    logic             is_tx, is_rx, is_stat, legal, blocked, timeout;
    logic             active, done, err_c, ok_c, wr_ok;
    logic [2:0]       cfg_idx;
    logic [DATA_W-1:0] rd_mux;

    assign cfg_idx  = PADDR[4:2];
    assign hit_tx   = (PADDR == 8'h00);
    assign hit_rx   = (PADDR == 8'h04);
    assign hit_stat = (PADDR == 8'h08);
    assign hit_ien  = (PADDR == 8'h0C);
    assign hit_ist  = (PADDR == 8'h10);
    assign cfg_hit  = (PADDR[7:5] == 3'b001) && (PADDR[1:0] == 2'b00) && ({1'b0, cfg_idx} < NCFG);

    assign is_tx   = hit_tx & PWRITE;
    assign is_rx   = hit_rx & ~PWRITE;
    assign is_stat = hit_stat & ~PWRITE;
    assign legal   = is_tx | is_rx | is_stat | hit_ien | hit_ist | cfg_hit;

    // ACCESS is the first enable cycle and is never held in state_q; dropping PSELx in WAIT aborts.
    always_comb begin
        cur_st = ST_IDLE;
        if (state_q == ST_WAIT) begin
            cur_st = PSELx ? ST_WAIT : ST_IDLE;
        end else if (PSELx && PENABLE) begin
            cur_st = ST_ACCESS;
        end
    end

    assign cnt_eff = (cur_st == ST_WAIT) ? cnt_q : 10'd0;
    assign blocked = (is_tx && TX_FULL) || (is_rx && RX_EMPTY);
    assign timeout = blocked && (cnt_eff >= STALL_LIM);
    assign active  = (cur_st != ST_IDLE) && !PRESET;
    assign done    = active && (!blocked || timeout);
    assign err_c   = done && (!legal || blocked);
    assign ok_c    = done && !err_c;
    assign wr_ok   = ok_c && PWRITE;

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = 10'd0;
        if (active && !done) begin
            state_d = ST_WAIT;
            cnt_d   = cnt_eff + 10'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_rx) begin
            rd_mux = RX_RDATA;
        end else if (is_stat) begin
            rd_mux[7:0] = {ist_q, ERROR, RX_EMPTY, TX_EMPTY, TX_FULL};
        end else if (hit_ien) begin
            rd_mux[3:0] = ien_q;
        end else if (hit_ist) begin
            rd_mux[3:0] = ist_q;
        end else if (cfg_hit) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_idx == 3'(i)) rd_mux[CFG_W-1:0] = cfg_q[i];
            end
        end
    end

    // Event set wins over a same-cycle write-1-to-clear.
    always_comb begin
        ist_set = {done && blocked, ERROR & ~error_q, rx_empty_q & ~RX_EMPTY, TX_EMPTY & ~tx_empty_q};
        ist_clr = (wr_ok && hit_ist) ? PWDATA[3:0] : 4'd0;
        ist_d   = (ist_q & ~ist_clr) | ist_set;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 10'd0;
            ien_q      <= 4'd0;
            ist_q      <= 4'd0;
            tx_empty_q <= 1'b0;
            rx_empty_q <= 1'b0;
            error_q    <= 1'b0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ist_q      <= ist_d;
            tx_empty_q <= TX_EMPTY;
            rx_empty_q <= RX_EMPTY;
            error_q    <= ERROR;
            irq_q      <= |(ist_q & ien_q);
            if (wr_ok && hit_ien) ien_q <= PWDATA[3:0];
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_ok && cfg_hit && (cfg_idx == 3'(i))) cfg_q[i] <= PWDATA[CFG_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign CFG_REGS[g*CFG_W +: CFG_W] = cfg_q[g];
    end

    assign PREADY   = done;
    assign PSLVERR  = err_c;
    assign TX_WR    = ok_c & is_tx;
    assign RX_RD    = ok_c & is_rx;
    assign TX_WDATA = PWDATA;
    assign PRDATA   = (ok_c && !PWRITE) ? rd_mux : '0;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Directed bench for apb_i2c_regbank: APB transfers with hand-computed expectations,
// FIFO stalls, timeout, interrupts and reset during a wait.
module tb_apb_i2c_regbank;

    logic        PCLK = 1'b0;
    logic        PRESET, PSELx, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA, TX_WDATA, RX_RDATA;
    logic        PREADY, PSLVERR, TX_WR, TX_FULL, TX_EMPTY, RX_RD, RX_EMPTY, ERROR, IRQ;
    logic [55:0] CFG_REGS;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] r_rdata, r_txwdata;
    logic        r_err, r_done, r_txwr_last;
    int          r_waits, r_txwr_cnt, r_rxrd_cnt;

    apb_i2c_regbank #(.DATA_W(32), .NUM_CFG(4), .CFG_W(14), .STALL_MAX(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TX_WDATA(TX_WDATA), .TX_WR(TX_WR), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
        .RX_RDATA(RX_RDATA), .RX_RD(RX_RD), .RX_EMPTY(RX_EMPTY), .ERROR(ERROR),
        .CFG_REGS(CFG_REGS), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One APB transfer; raise_err asserts ERROR together with PENABLE.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic raise_err);
        int cyc;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (raise_err) ERROR = 1'b1;
        r_waits = 0; r_txwr_cnt = 0; r_rxrd_cnt = 0; r_done = 1'b0;
        r_rdata = '0; r_err = 1'b0; r_txwdata = '0; r_txwr_last = 1'b0;
        cyc = 0;
        while (!r_done && cyc < 64) begin
            @(negedge PCLK);
            if (TX_WR) r_txwr_cnt++;
            if (RX_RD) r_rxrd_cnt++;
            if (PREADY) begin
                r_done = 1'b1; r_rdata = PRDATA; r_err = PSLVERR;
                r_txwdata = TX_WDATA; r_txwr_last = TX_WR;
            end else begin
                r_waits++;
            end
            cyc++;
            @(posedge PCLK); #1;
        end
        PSELx = 1'b0; PENABLE = 1'b0;
        check_val("xfer_done", 64'(r_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h08;
        PWDATA = '0; TX_FULL = 1'b0; TX_EMPTY = 1'b0; RX_EMPTY = 1'b1; ERROR = 1'b0;
        RX_RDATA = 32'hA5A5_0001;

        // Reset with a read presented: everything held low.
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_val("rst_pready", 64'(PREADY), 64'd0);
        check_val("rst_prdata", 64'(PRDATA), 64'd0);
        check_val("rst_pslverr", 64'(PSLVERR), 64'd0);
        check_val("rst_irq", 64'(IRQ), 64'd0);
        check_val("rst_cfg", CFG_REGS, 64'd0);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // CFG write/readback, including truncation to 14 bits
        apb_xfer(1'b1, 8'h20, 32'h0000_1234, 1'b0);
        check_val("cfg0_wr_waits", 64'(r_waits), 64'd0);
        check_val("cfg0_wr_err", 64'(r_err), 64'd0);
        check_val("cfg0_wr_txwr", 64'(r_txwr_cnt), 64'd0);
        check_val("cfg0_regs", 64'(CFG_REGS[13:0]), 64'h1234);
        apb_xfer(1'b0, 8'h20, 32'h0, 1'b0);
        check_val("cfg0_rd_data", 64'(r_rdata), 64'h1234);
        check_val("cfg0_rd_waits", 64'(r_waits), 64'd0);
        check_val("cfg0_rd_err", 64'(r_err), 64'd0);
        apb_xfer(1'b1, 8'h24, 32'hFFFF_5678, 1'b0);
        apb_xfer(1'b0, 8'h24, 32'h0, 1'b0);
        check_val("cfg1_rd_data", 64'(r_rdata), 64'h1678);
        check_val("cfg_regs_all", CFG_REGS, 64'h0000_0000_59E1234);

        // STATUS: TX_FULL=0 TX_EMPTY=0 RX_EMPTY=1 ERROR=0, no IRQ bits
        apb_xfer(1'b0, 8'h08, 32'h0, 1'b0);
        check_val("status_rd", 64'(r_rdata), 64'h4);

        // TX write stalled 5 cycles by TX_FULL
        TX_FULL = 1'b1;
        fork
            apb_xfer(1'b1, 8'h00, 32'hDEAD_BEEF, 1'b0);
            begin
                wait (PENABLE === 1'b1);
                repeat (5) @(posedge PCLK);
                #1 TX_FULL = 1'b0;
            end
        join
        check_val("tx_waits", 64'(r_waits), 64'd5);
        check_val("tx_err", 64'(r_err), 64'd0);
        check_val("tx_wr_cnt", 64'(r_txwr_cnt), 64'd1);
        check_val("tx_wr_last", 64'(r_txwr_last), 64'd1);
        check_val("tx_wdata", 64'(r_txwdata), 64'hDEAD_BEEF);

        // RX read with RX_EMPTY stuck: timeout after 8 waits
        apb_xfer(1'b0, 8'h04, 32'h0, 1'b0);
        check_val("rxto_waits", 64'(r_waits), 64'd8);
        check_val("rxto_err", 64'(r_err), 64'd1);
        check_val("rxto_rxrd", 64'(r_rxrd_cnt), 64'd0);
        check_val("rxto_prdata", 64'(r_rdata), 64'd0);
        apb_xfer(1'b0, 8'h10, 32'h0, 1'b0);
        check_val("rxto_ist", 64'(r_rdata), 64'h8);
        check_val("rxto_irq_masked", 64'(IRQ), 64'd0);

        // RX data present: RX_EMPTY falling sets bit 1
        RX_EMPTY = 1'b0;
        apb_xfer(1'b0, 8'h04, 32'h0, 1'b0);
        check_val("rx_data", 64'(r_rdata), 64'hA5A5_0001);
        check_val("rx_waits", 64'(r_waits), 64'd0);
        check_val("rx_rd_cnt", 64'(r_rxrd_cnt), 64'd1);
        apb_xfer(1'b0, 8'h10, 32'h0, 1'b0);
        check_val("rx_ist", 64'(r_rdata), 64'hA);
        apb_xfer(1'b1, 8'h10, 32'hF, 1'b0);
        apb_xfer(1'b0, 8'h10, 32'h0, 1'b0);
        check_val("ist_cleared", 64'(r_rdata), 64'h0);

        // ERROR interrupt path
        apb_xfer(1'b1, 8'h0C, 32'h4, 1'b0);
        apb_xfer(1'b0, 8'h0C, 32'h0, 1'b0);
        check_val("ien_rd", 64'(r_rdata), 64'h4);
        @(posedge PCLK); #1;
        ERROR = 1'b1;
        @(posedge PCLK); #1;
        check_val("irq_lag", 64'(IRQ), 64'd0);
        ERROR = 1'b0;
        @(posedge PCLK); #1;
        check_val("irq_set", 64'(IRQ), 64'd1);
        apb_xfer(1'b1, 8'h10, 32'h4, 1'b0);
        @(posedge PCLK); #1;
        check_val("irq_w1c", 64'(IRQ), 64'd0);
        apb_xfer(1'b1, 8'h10, 32'h4, 1'b1);
        ERROR = 1'b0;
        apb_xfer(1'b0, 8'h10, 32'h0, 1'b0);
        check_val("ist_set_wins", 64'(r_rdata), 64'h4);
        check_val("irq_set_wins", 64'(IRQ), 64'd1);

        // Error responses leave state alone
        apb_xfer(1'b1, 8'h44, 32'h0000_3FFF, 1'b0);
        check_val("bad44_err", 64'(r_err), 64'd1);
        check_val("bad44_waits", 64'(r_waits), 64'd0);
        check_val("bad44_txwr", 64'(r_txwr_cnt), 64'd0);
        check_val("bad44_cfg", CFG_REGS, 64'h0000_0000_59E1234);
        apb_xfer(1'b0, 8'h00, 32'h0, 1'b0);
        check_val("rd00_err", 64'(r_err), 64'd1);
        check_val("rd00_waits", 64'(r_waits), 64'd0);
        check_val("rd00_data", 64'(r_rdata), 64'd0);
        apb_xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 1'b0);
        check_val("wr08_err", 64'(r_err), 64'd1);

        // Reset in the middle of a stalled TX write
        TX_FULL = 1'b1;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h1111_2222;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b1; TX_FULL = 1'b0;
        @(negedge PCLK);
        check_val("mrst_pready", 64'(PREADY), 64'd0);
        check_val("mrst_pslverr", 64'(PSLVERR), 64'd0);
        check_val("mrst_txwr", 64'(TX_WR), 64'd0);
        check_val("mrst_rxrd", 64'(RX_RD), 64'd0);
        check_val("mrst_prdata", 64'(PRDATA), 64'd0);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        check_val("mrst_irq", 64'(IRQ), 64'd0);
        check_val("mrst_cfg", CFG_REGS, 64'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        check_val("post_rst_pready", 64'(PREADY), 64'd0);
        apb_xfer(1'b0, 8'h0C, 32'h0, 1'b0);
        check_val("post_rst_waits", 64'(r_waits), 64'd0);
        check_val("post_rst_ien", 64'(r_rdata), 64'd0);
        check_val("post_rst_err", 64'(r_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
